// File: rtl/lda_pixel_sink_pkg.sv
// Shared types and constants for the line-drawer pixel sink: screen geometry,
// the buffered pixel record, the write FSM state and the linear-address helper.
package lda_pixel_sink_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int ADDR_W   = 17;
    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int COL_W    = 3;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [COL_W-1:0] col;
    } pixel_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // y*320 + x built from two shifts; the result never exceeds 76799.
    function automatic logic [ADDR_W-1:0] lin_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
        return ADDR_W'({y, 8'd0}) + ADDR_W'({y, 6'd0}) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/lda_pixel_sink_if.sv
// Plot strobe from the drawer and the write port toward the framebuffer memory.
interface lda_pixel_sink_if;
    import lda_pixel_sink_pkg::*;

    // i_plot is a one-shot strobe with no ready: a pixel is offered for exactly
    // the cycle i_plot is high. o_mem_we is a valid that, once raised, holds
    // o_mem_addr/o_mem_data stable until a rising edge sees i_mem_ack high.
    logic              i_plot;
    logic [X_W-1:0]    i_x;
    logic [Y_W-1:0]    i_y;
    logic [COL_W-1:0]  i_col;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [COL_W-1:0]  o_mem_data;
    logic              i_mem_ack;

    modport slave (
        input  i_plot, i_x, i_y, i_col, i_mem_ack,
        output o_mem_we, o_mem_addr, o_mem_data
    );

    modport master (
        output i_plot, i_x, i_y, i_col, i_mem_ack,
        input  o_mem_we, o_mem_addr, o_mem_data
    );

endinterface

// File: rtl/lda_pixel_sink_pixel_fifo.sv
// First-word-fall-through pixel FIFO with occupancy count; push and pop may
// coincide even when full, and flush empties it synchronously.
module pixel_fifo
    import lda_pixel_sink_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  pixel_t        din,
    output pixel_t        dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    pixel_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lda_pixel_sink.sv
// Pixel sink: clips off-screen plots, queues the rest, and writes each one to
// the framebuffer through an ack-handshaked port, reporting backpressure and drain.
module lda_pixel_sink
    import lda_pixel_sink_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    lda_pixel_sink_if.slave     bus,
    input  logic                i_done,
    input  logic                i_clear,
    output logic                o_full,
    output logic                o_almost_full,
    output logic                o_idle,
    output logic                o_frame_done,
    output logic                o_overflow,
    output logic [7:0]          o_clip_cnt,
    output state_t              o_dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_W);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_H);

    state_t            state;
    pixel_t            pix_q;
    pixel_t            fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [COL_W-1:0]  mem_data;
    logic              done_pending;
    logic              in_range;
    logic              pop;
    logic              push;

    assign in_range = (bus.i_x < X_LIM) && (bus.i_y < Y_LIM);
    assign pop  = !i_clear && !fifo_empty &&
                  ((state == S_IDLE) || (state == S_WRITE && bus.i_mem_ack));
    assign push = !i_clear && bus.i_plot && in_range && (!fifo_full || pop);

    pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (i_clear),
        .push    (push),
        .pop     (pop),
        .din     ('{x: bus.i_x, y: bus.i_y, col: bus.i_col}),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign o_full        = fifo_full;
    assign o_almost_full = (fifo_count >= CW'(DEPTH - AF_MARGIN));
    assign o_idle        = fifo_empty && (state == S_IDLE);
    assign o_frame_done  = done_pending && o_idle;
    assign o_dbg_state   = state;
    assign bus.o_mem_we   = mem_we;
    assign bus.o_mem_addr = mem_addr;
    assign bus.o_mem_data = mem_data;

    // Write FSM: IDLE pops into pix_q, ADDR forms the address, WRITE holds the request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            pix_q    <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else if (i_clear) begin
            state  <= S_IDLE;
            mem_we <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        pix_q <= fifo_dout;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    mem_addr <= lin_addr(pix_q.x, pix_q.y);
                    mem_data <= pix_q.col;
                    mem_we   <= 1'b1;
                    state    <= S_WRITE;
                end
                S_WRITE: begin
                    if (bus.i_mem_ack) begin
                        mem_we <= 1'b0;
                        if (!fifo_empty) begin
                            pix_q <= fifo_dout;
                            state <= S_ADDR;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_overflow   <= 1'b0;
            o_clip_cnt   <= '0;
            done_pending <= 1'b0;
        end else if (i_clear) begin
            o_overflow   <= 1'b0;
            o_clip_cnt   <= '0;
            done_pending <= 1'b0;
        end else begin
            if (bus.i_plot && !in_range && o_clip_cnt != 8'hFF)
                o_clip_cnt <= o_clip_cnt + 8'd1;
            if (bus.i_plot && in_range && !push)
                o_overflow <= 1'b1;
            // The pulse cycle itself swallows any i_done arriving alongside it.
            if (o_frame_done)
                done_pending <= 1'b0;
            else if (i_done)
                done_pending <= 1'b1;
        end
    end

endmodule
